stage_if: RTL and testbench



---
 rtl/stage_if_pkg.sv | 22 ++
 rtl/if_sat_counter.sv | 26 ++
 rtl/stage_if.sv | 103 ++++++++++
 tb/tb_stage_if.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/stage_if_pkg.sv
// Shared constants and helpers for the IF stage (next-PC select codes, NOP, reset PC).
// Optional build macro used by the stage: IF_FLUSH_EN (no-delay-slot mode).
package stage_if_pkg;

    localparam logic [1:0]  PC_SEL_SEQ = 2'b00;
    localparam logic [1:0]  PC_SEL_BR  = 2'b01;
    localparam logic [1:0]  PC_SEL_JR  = 2'b10;
    localparam logic [1:0]  PC_SEL_J   = 2'b11;

    localparam logic [31:0] INSTR_NOP        = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Register-indirect jump target: word-aligned by dropping the low two bits.
    function automatic logic [31:0] jr_target(input logic [31:0] rs_val);
        return {rs_val[31:2], 2'b00};
    endfunction

    function automatic logic jr_misaligned(input logic [31:0] rs_val);
        return (rs_val[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_sat_counter.sv
// Saturating up-counter used for the IF-stage performance counters.
module if_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset_0,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_count;
    logic             w_full;

    assign w_full = &r_count;

    always_ff @(posedge clock) begin
        if (reset_0) begin
            r_count <= '0;
        end else if (inc && !w_full) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/stage_if.sv
// IF stage: PC register, next-PC selection, IF/ID pipeline register and perf counters.
// Build macro IF_FLUSH_EN: squash the delay-slot instruction on any redirect.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset_0,
    input  logic             stall,
    input  logic [1:0]       pc_select,
    input  logic [31:0]      pc_b,
    input  logic [31:0]      pc_j,
    input  logic [31:0]      a_id,
    input  logic [31:0]      imem_data,
    output logic [31:0]      imem_addr,
    output logic [31:0]      pc4_id,
    output logic [31:0]      instr_id,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic             pc_misalign
);

    logic [31:0] r_pc;
    logic [31:0] r_pc4_id;
    logic [31:0] r_instr_id;
    logic        r_misalign;

    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;
    logic [31:0] w_if_instr;
    logic        w_redirect;
    logic        w_fetch_inc;

    assign w_pc4      = r_pc + 32'd4;
    assign w_redirect = (pc_select != PC_SEL_SEQ);

    always_comb begin
        w_next_pc = w_pc4;
        case (pc_select)
            PC_SEL_SEQ: w_next_pc = w_pc4;
            PC_SEL_BR:  w_next_pc = pc_b;
            PC_SEL_JR:  w_next_pc = jr_target(a_id);
            PC_SEL_J:   w_next_pc = pc_j;
            default:    w_next_pc = w_pc4;
        endcase
    end

`ifdef IF_FLUSH_EN
    // The slot behind a taken redirect becomes a bubble and is not counted as a fetch.
    assign w_if_instr  = w_redirect ? INSTR_NOP : imem_data;
    assign w_fetch_inc = !stall && !w_redirect;
`else
    assign w_if_instr  = imem_data;
    assign w_fetch_inc = !stall;
`endif

    // During a stall the ID operands are stale, so pc_select is deliberately ignored.
    always_ff @(posedge clock) begin
        if (reset_0) begin
            r_pc       <= RESET_PC;
            r_pc4_id   <= 32'd0;
            r_instr_id <= INSTR_NOP;
        end else if (!stall) begin
            r_pc       <= w_next_pc;
            r_pc4_id   <= w_pc4;
            r_instr_id <= w_if_instr;
        end
    end

    always_ff @(posedge clock) begin
        if (reset_0) begin
            r_misalign <= 1'b0;
        end else if (!stall && pc_select == PC_SEL_JR && jr_misaligned(a_id)) begin
            r_misalign <= 1'b1;
        end
    end

    if_sat_counter #(.CNT_W(CNT_W)) u_fetch_cnt (
        .clock   (clock),
        .reset_0 (reset_0),
        .inc     (w_fetch_inc),
        .count   (fetch_cnt)
    );

    if_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clock   (clock),
        .reset_0 (reset_0),
        .inc     (stall),
        .count   (stall_cnt)
    );

    assign imem_addr   = r_pc;
    assign pc4_id      = r_pc4_id;
    assign instr_id    = r_instr_id;
    assign pc_misalign = r_misalign;

    // Redirect is only observable through w_next_pc in delay-slot builds.
    logic w_unused;
    assign w_unused = w_redirect;

endmodule

// File: tb/tb_stage_if.sv
// Scoreboard bench for stage_if: directed sequence then random traffic vs. a behavioural model.
module tb_stage_if;

    localparam int          CNT_W = 6;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             reset_0 = 1'b1;
    logic             stall = 1'b0;
    logic [1:0]       pc_select = 2'b00;
    logic [31:0]      pc_b = '0, pc_j = '0, a_id = '0;
    logic [31:0]      imem_data, imem_addr, pc4_id, instr_id;
    logic [CNT_W-1:0] fetch_cnt, stall_cnt;
    logic             pc_misalign;

    int total = 0;
    int bad   = 0;
    int txn   = 0;

    typedef struct packed {
        logic [31:0]      pc;
        logic [31:0]      pc4;
        logic [31:0]      instr;
        logic [CNT_W-1:0] fetch;
        logic [CNT_W-1:0] stl;
        logic             mis;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: the architectural meaning of each output.
    logic [31:0]      m_pc    = RPC;
    logic [31:0]      m_pc4   = '0;
    logic [31:0]      m_instr = '0;
    int               m_fetch = 0;
    int               m_stall = 0;
    logic             m_mis   = 1'b0;
    localparam int    CMAX    = (1 << CNT_W) - 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
    endfunction

    assign imem_data = mem_word(imem_addr);

    stage_if #(.RESET_PC(RPC), .CNT_W(CNT_W)) dut (
        .clock       (clk),
        .reset_0     (reset_0),
        .stall       (stall),
        .pc_select   (pc_select),
        .pc_b        (pc_b),
        .pc_j        (pc_j),
        .a_id        (a_id),
        .imem_data   (imem_data),
        .imem_addr   (imem_addr),
        .pc4_id      (pc4_id),
        .instr_id    (instr_id),
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt),
        .pc_misalign (pc_misalign)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs and push what the outputs must be after the next edge.
    task automatic cycle(input logic rst, input logic st, input logic [1:0] sel,
                         input logic [31:0] pb, input logic [31:0] pj, input logic [31:0] ra);
        exp_t e;
        logic [31:0] target;
        @(negedge clk);
        reset_0 = rst; stall = st; pc_select = sel; pc_b = pb; pc_j = pj; a_id = ra;
        if (rst) begin
            m_pc = RPC; m_pc4 = 0; m_instr = 0; m_fetch = 0; m_stall = 0; m_mis = 0;
        end else if (st) begin
            if (m_stall < CMAX) m_stall++;
        end else begin
            case (sel)
                2'd1:    target = pb;
                2'd2:    target = ra & 32'hFFFF_FFFC;
                2'd3:    target = pj;
                default: target = m_pc + 32'd4;
            endcase
            if (sel == 2'd2 && ra[1:0] != 0) m_mis = 1'b1;
            m_pc4 = m_pc + 32'd4;
`ifdef IF_FLUSH_EN
            m_instr = (sel != 0) ? 32'h0 : mem_word(m_pc);
            if (sel == 0 && m_fetch < CMAX) m_fetch++;
`else
            m_instr = mem_word(m_pc);
            if (m_fetch < CMAX) m_fetch++;
`endif
            m_pc = target;
        end
        e.pc = m_pc; e.pc4 = m_pc4; e.instr = m_instr;
        e.fetch = CNT_W'(m_fetch); e.stl = CNT_W'(m_stall); e.mis = m_mis;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL txn=%0d %s actual=%h required=%h", txn, name, act, req);
        end
    endtask

    // Monitor: every edge is an output event for this stage.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                txn++;
                chk("imem_addr",   imem_addr,           e.pc);
                chk("pc4_id",      pc4_id,              e.pc4);
                chk("instr_id",    instr_id,            e.instr);
                chk("fetch_cnt",   32'(fetch_cnt),      32'(e.fetch));
                chk("stall_cnt",   32'(stall_cnt),      32'(e.stl));
                chk("pc_misalign", 32'(pc_misalign),    32'(e.mis));
                $display("txn %0d: rst=%0b stall=%0b sel=%0d pc=%h pc4_id=%h instr=%h fc=%0d sc=%0d mis=%0b",
                         txn, reset_0, stall, pc_select, imem_addr, pc4_id, instr_id,
                         fetch_cnt, stall_cnt, pc_misalign);
            end
        end
    end

    initial begin
        // Directed: sequential fetch, stall, branch, jr misaligned, stalled jump, wrap.
        cycle(1, 0, 2'd0, 0, 0, 0);
        cycle(0, 0, 2'd0, 0, 0, 0);
        cycle(0, 0, 2'd0, 0, 0, 0);
        cycle(0, 1, 2'd0, 0, 0, 0);
        cycle(0, 1, 2'd1, 32'h80, 0, 0);
        cycle(0, 0, 2'd0, 0, 0, 0);
        cycle(0, 0, 2'd0, 0, 0, 0);
        cycle(0, 0, 2'd1, 32'h40, 0, 0);
        cycle(0, 0, 2'd2, 0, 0, 32'h0000_0103);
        cycle(0, 0, 2'd0, 0, 0, 0);
        cycle(0, 1, 2'd3, 0, 32'h300, 0);
        cycle(0, 0, 2'd3, 0, 32'h200, 0);
        cycle(0, 0, 2'd2, 0, 0, 32'h0000_0204);
        cycle(0, 0, 2'd3, 0, 32'hFFFF_FFFC, 0);
        cycle(0, 0, 2'd0, 0, 0, 0);
        cycle(0, 0, 2'd0, 0, 0, 0);
        cycle(1, 1, 2'd3, 0, 32'h500, 0);
        cycle(0, 1, 2'd1, 32'h600, 0, 0);
        cycle(0, 0, 2'd0, 0, 0, 0);
        // Random traffic; long reset-free stretches let the counters saturate.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                  2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
        end
        cycle(0, 0, 2'd0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
